csa_seq_skip_adder: RTL and testbench

CSA_SEQ_SKIP_ADDER -- requirements
Module: csa_seq_skip_adder

---
 rtl/csa_seq_skip_adder.sv | 152 +++++++++++++++
 tb/tb_csa_seq_skip_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/csa_seq_skip_adder.sv
// Purpose : sequential carry-skip adder, one BLK-bit block per cycle, skip path chosen per block.
// Latency : out_valid rises exactly NBLK rising edges after the accepting edge.
// Backpr. : in_ready only in IDLE; result held in DONE until out_ready; in_valid ignored otherwise.
//
// Ports:
//   clk, rst                  clock (rising edge) and synchronous active-high reset
//   in_valid / in_ready       operand handshake for a, b, cin
//   a, b [WIDTH-1:0], cin     addends and carry-in
//   out_valid / out_ready     result handshake for sum, cout, skip_mask
//   sum [WIDTH-1:0], cout     result modulo 2^WIDTH and overflow carry
//   skip_mask [NBLK-1:0]      bit k set when block k's carry took the skip path
//
// Optional build macro: CSA_APPROX_LSB_EN -- block 0 becomes an approximate OR-adder
// (sum = a|b, carry-out = a[BLK-1]&b[BLK-1], cin ignored, skip_mask[0] = 0).
module csa_seq_skip_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      sum,
    output logic                  cout,
    output logic [WIDTH/BLK-1:0]  skip_mask
);

    localparam int NBLK = WIDTH / BLK;
    localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic [NBLK-1:0]   mask_q;

    // Current-block datapath
    logic [BLK-1:0]    blk_a;
    logic [BLK-1:0]    blk_b;
    logic [BLK-1:0]    blk_p;
    logic [BLK-1:0]    blk_sum;
    logic [BLK:0]      rc_chain;
    logic              blk_rc;
    logic              blk_skip;
    logic              carry_next;
    logic              last_blk;

    assign last_blk = (idx_q == IDXW'(NBLK - 1));

    always_comb begin
        blk_a       = a_q[int'(idx_q)*BLK +: BLK];
        blk_b       = b_q[int'(idx_q)*BLK +: BLK];
        blk_p       = blk_a ^ blk_b;
        blk_sum     = '0;
        rc_chain    = '0;
        rc_chain[0] = carry_q;
        for (int i = 0; i < BLK; i++) begin
            blk_sum[i]    = blk_p[i] ^ rc_chain[i];
            rc_chain[i+1] = (blk_a[i] & blk_b[i]) | (blk_p[i] & rc_chain[i]);
        end
        blk_rc     = rc_chain[BLK];
        // When every bit propagates, the block's carry-out is just its carry-in.
        blk_skip   = &blk_p;
        carry_next = blk_skip ? carry_q : blk_rc;
`ifdef CSA_APPROX_LSB_EN
        if (idx_q == '0) begin
            blk_sum    = blk_a | blk_b;
            blk_rc     = blk_a[BLK-1] & blk_b[BLK-1];
            blk_skip   = 1'b0;
            carry_next = blk_rc;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = BUSY;
            BUSY: if (last_blk) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and per-block result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            mask_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        mask_q  <= '0;
                    end
                end
                BUSY: begin
                    sum_q[int'(idx_q)*BLK +: BLK] <= blk_sum;
                    mask_q[idx_q]                 <= blk_skip;
                    carry_q                       <= carry_next;
                    idx_q                         <= idx_q + 1'b1;
                    if (last_blk) begin
                        cout_q <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign skip_mask = mask_q;

endmodule

// File: tb/tb_csa_seq_skip_adder.sv
module tb_csa_seq_skip_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  skip_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_seq_skip_adder #(.WIDTH(16), .BLK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .skip_mask (skip_mask)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present operands, wait for the accept edge, then count edges until out_valid.
    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                         output int lat);
        int n;
        @(negedge clk);
        a = ia; b = ib; cin = ic; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int nacc;
        int nres;
        int acc_t[3];
        logic [15:0] held_sum;
        logic [15:0] bb_a[3];
        logic [15:0] bb_b[3];
        logic [15:0] bb_s[3];
        logic        bb_c[3];
        bit          seen_valid;

        vecs[0]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b1111};
        vecs[1]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000};
        vecs[2]  = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 4'b0000};
        vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110};
        vecs[4]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0000};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'b0000};
        vecs[6]  = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 4'b1111};
        vecs[7]  = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 4'b1111};
        vecs[8]  = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 4'b0000};
        vecs[9]  = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 4'b0111};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'b0000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_mask", 32'(skip_mask), 32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
            chk($sformatf("vec%0d_mask", i), 32'(skip_mask), 32'(vecs[i].mask));
            consume();
            chk($sformatf("vec%0d_idle", i), 32'(in_ready), 32'd1);
        end

        // Result held under backpressure; new operands must be ignored
        do_op(16'h1234, 16'h4321, 1'b0, lat);
        held_sum = sum;
        chk("hold_first_sum", 32'(held_sum), 32'h5555);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_sum", i), 32'(sum), 32'h5555);
            chk($sformatf("hold%0d_mask", i), 32'(skip_mask), 32'h0);
            chk($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("reaccept_busy", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("reaccept_latency", 32'(lat), 32'd4);
        chk("reaccept_sum", 32'(sum), 32'h0000);
        chk("reaccept_cout", 32'(cout), 32'd1);
        chk("reaccept_mask", 32'(skip_mask), 32'hF);
        consume();

        // Reset two cycles after accept aborts the operation
        @(negedge clk);
        a = 16'h7FFF; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_mask", 32'(skip_mask), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("abort_no_stale", 32'(seen_valid), 32'd0);

        // Back-to-back with out_ready tied high
        bb_a[0] = 16'h1234; bb_b[0] = 16'h4321; bb_s[0] = 16'h5555; bb_c[0] = 1'b0;
        bb_a[1] = 16'hFFFF; bb_b[1] = 16'h0001; bb_s[1] = 16'h0000; bb_c[1] = 1'b1;
        bb_a[2] = 16'hA5A5; bb_b[2] = 16'h5A5A; bb_s[2] = 16'hFFFF; bb_c[2] = 1'b0;
        out_ready = 1'b1;
        cin = 1'b0;
        nacc = 0;
        nres = 0;
        for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                chk($sformatf("b2b%0d_sum", nres), 32'(sum), 32'(bb_s[nres]));
                chk($sformatf("b2b%0d_cout", nres), 32'(cout), 32'(bb_c[nres]));
                nres++;
            end
            if (in_ready) begin
                if (nacc < 3) begin
                    acc_t[nacc] = cyc;
                    a = bb_a[nacc];
                    b = bb_b[nacc];
                    in_valid = 1'b1;
                    nacc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_results", 32'(nres), 32'd3);
        if (nacc == 3) begin
            chk("b2b_period01", 32'(acc_t[1] - acc_t[0]), 32'd6);
            chk("b2b_period12", 32'(acc_t[2] - acc_t[1]), 32'd6);
        end else begin
            chk("b2b_accepts", 32'(nacc), 32'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
